dsp_mac_pipe: RTL and testbench
===============================

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 SHALL have parameter A_WIDTH, default 18: signed A operand width.
REQ-002 SHALL have parameter B_WIDTH, default 18: signed B and D operand width.
REQ-003 SHALL have parameter P_WIDTH, default 48: signed result width; legal only when P_WIDTH >= A_WIDTH+B_WIDTH+1.
REQ-004 SHALL have parameter ACC_LEN, default 16: maximum number of samples in one accumulation group, 1..65535.
REQ-005 SHALL have parameter SATURATE, default 1: 1 clamps on overflow, 0 wraps.
REQ-006 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port RSTN, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port IN_VALID, input, 1: input sample present.
REQ-009 SHALL have port IN_READY, output, 1: the block accepts a sample this cycle.
REQ-010 SHALL have port IN_LAST, input, 1: the sample closes an accumulation group.
REQ-011 SHALL have ports A (A_WIDTH), B (B_WIDTH), D (B_WIDTH) and C (P_WIDTH), all inputs and all signed operands.
REQ-012 SHALL have port OPMODE, input, 4 bits: [0] pre-adder enable, [1] pre-subtract, [2] post-subtract, [3] accumulate.
REQ-013 SHALL have ports OUT_VALID (output, 1) and OUT_READY (input, 1): result handshake.
REQ-014 SHALL have port P, output, P_WIDTH: the result.
REQ-015 SHALL have port OUT_LAST, output, 1: P is the end of a group.
REQ-016 SHALL have port OVF, output, 1: this result overflowed.
REQ-017 SHALL have port OVF_STICKY, output, 1: an overflow has occurred since reset.

Function
REQ-018 SHALL transfer a sample when IN_VALID && IN_READY, and SHALL transfer a result when OUT_VALID && OUT_READY.
REQ-019 SHALL drive IN_READY = !(OUT_VALID && !OUT_READY): the global stall condition.
REQ-020 SHALL hold every pipeline stage unchanged while stalled, and SHALL never drop or duplicate a sample.
REQ-021 SHALL use four stages: S1 registers A/B/D/C/OPMODE/IN_LAST; S2 pre-adder; S3 multiplier; S4 post-adder/accumulator.
REQ-022 SHALL carry a valid bit with each stage; empty slots (bubble) SHALL advance without touching the accumulator.
REQ-023 SHALL form the pre-adder output as sign-extended B_WIDTH+1 bits: OPMODE[0]=0 -> B; OPMODE[0]=1,[1]=0 -> D+B; OPMODE[0]=1,[1]=1 -> D-B.
REQ-024 SHALL compute the signed product M = A * pre-adder output, width A_WIDTH+B_WIDTH+1, sign-extended to P_WIDTH.
REQ-025 SHALL select Z = C when OPMODE[3]=0 or on the first sample of a group, and Z = accumulator otherwise.
REQ-026 SHALL compute the sum in P_WIDTH+1 bits as Z+M (OPMODE[2]=0) or Z-M (OPMODE[2]=1).
REQ-027 SHALL treat the sum as overflowed when bit P_WIDTH differs from bit P_WIDTH-1.
REQ-028 SHALL on overflow, with SATURATE=1, clamp to the maximum positive value (sum>0) or the minimum negative value (sum<0).
REQ-029 SHALL on overflow, with SATURATE=0, keep the low P_WIDTH bits.
REQ-030 SHALL, when an overflowed value is loaded into the accumulator, OR the overflow into a per-group flag, and SHALL set OVF_STICKY, which stays set until reset.
REQ-031 SHALL, for a non-accumulate sample (OPMODE[3]=0), present its result with OUT_VALID=1, OUT_LAST=1 and OVF equal to that sample's overflow.
REQ-032 SHALL keep a group counter, width ceil(log2(ACC_LEN+1)).
REQ-033 SHALL treat an accumulate sample as closing its group when IN_LAST=1 or the counter reaches ACC_LEN-1.
REQ-034 SHALL emit one result per group, at the closing sample, with OUT_LAST=1 and OVF equal to the per-group flag, then clear the counter and the flag.
REQ-035 SHALL load the accumulator for a non-closing accumulate sample without asserting OUT_VALID.
REQ-036 SHALL, when a non-accumulate sample arrives mid-group, discard the open group and start the next accumulate sample as first-of-group.
REQ-037 SHALL have a latency of exactly 4 unstalled cycles from accepting the closing sample to OUT_VALID.
REQ-038 SHALL sustain a throughput of 1 sample per cycle while OUT_READY=1.
REQ-039 SHALL hold P, OUT_LAST and OVF stable while OUT_VALID=1 and OUT_READY=0.

Reset
REQ-040 SHALL, on RSTN=0, immediately and without a clock clear all stage valids, the accumulator, the counter, the group flag, OVF_STICKY, P, OUT_VALID, OUT_LAST and OVF to 0; IN_READY SHALL then read 1.
REQ-041 SHALL discard any in-flight samples and any open group when reset is asserted mid-operation.
REQ-042 SHALL accept a sample on the first rising edge after RSTN deasserts.

Verification
REQ-043 SHALL be checked with single MAC: OPMODE=0001, A=3, B=4, D=10, C=100 -> P=142, OUT_LAST=1, OUT_VALID exactly 4 cycles after acceptance.
REQ-044 SHALL be checked with accumulate: OPMODE=1000, A=2, B=1..5 streamed, IN_LAST on 5th, C=7 -> one result P=37; no OUT_VALID for samples 1-4.
REQ-045 SHALL be checked with ACC_LEN=4, 10 accumulate samples A=B=1, C=0, no IN_LAST -> results 4, 4, then 2 on IN_LAST of sample 10.
REQ-046 SHALL be checked with saturation: P_WIDTH=37, C=2^36-1, A=B=1, OPMODE=0000 -> P=2^36-1, OVF=1, OVF_STICKY=1; SATURATE=0 -> P=-2^36.
REQ-047 SHALL be checked with backpressure: OUT_READY=0 for 6 cycles during a stream of 8 non-accumulate samples -> IN_READY drops, all 8 results in order, P stable while stalled.
REQ-048 SHALL be checked with RSTN pulsed low mid-group -> outputs 0 with no clock edge, no stale result afterwards, and the next group correct.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Four-stage signed pre-add / multiply / post-add MAC with group accumulation,
// optional saturation and a single global stall driven by result backpressure.
module dsp_mac_pipe #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int P_WIDTH  = 48,
    parameter int ACC_LEN  = 16,
    parameter int SATURATE = 1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic                       IN_LAST,
    input  logic signed [A_WIDTH-1:0]  A,
    input  logic signed [B_WIDTH-1:0]  B,
    input  logic signed [B_WIDTH-1:0]  D,
    input  logic signed [P_WIDTH-1:0]  C,
    input  logic        [3:0]          OPMODE,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic signed [P_WIDTH-1:0]  P,
    output logic                       OUT_LAST,
    output logic                       OVF,
    output logic                       OVF_STICKY
);

    localparam int  PW     = B_WIDTH + 1;
    localparam int  MW     = A_WIDTH + B_WIDTH + 1;
    localparam int  CW     = $clog2(ACC_LEN + 1);
    localparam bit  SAT_EN = (SATURATE != 0);
    localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    logic                       stall_s;
    // stage 1: registered operands
    logic                       v1_r, last1_r;
    logic signed [A_WIDTH-1:0]  a1_r;
    logic signed [B_WIDTH-1:0]  b1_r, d1_r;
    logic signed [P_WIDTH-1:0]  c1_r;
    logic        [3:0]          op1_r;
    // stage 2: pre-adder result; mode bits are {accumulate, post-subtract}
    logic                       v2_r, last2_r;
    logic signed [A_WIDTH-1:0]  a2_r;
    logic signed [PW-1:0]       pre2_r, pre_s;
    logic signed [P_WIDTH-1:0]  c2_r;
    logic        [1:0]          mode2_r;
    // stage 3: product
    logic                       v3_r, last3_r;
    logic signed [MW-1:0]       m3_r, m_s;
    logic signed [P_WIDTH-1:0]  c3_r;
    logic        [1:0]          mode3_r;
    // stage 4: accumulator and result registers
    logic signed [P_WIDTH-1:0]  acc_r, p_r, z_s, res_s;
    logic        [CW-1:0]       cnt_r;
    logic                       grp_ovf_r, out_valid_r, out_last_r, ovf_r, sticky_r;
    logic signed [P_WIDTH:0]    sum_s;
    logic                       ovf_s, first_s, close_s;

    assign stall_s    = out_valid_r && !OUT_READY;
    assign IN_READY   = !stall_s;
    assign OUT_VALID  = out_valid_r;
    assign P          = p_r;
    assign OUT_LAST   = out_last_r;
    assign OVF        = ovf_r;
    assign OVF_STICKY = sticky_r;

    // Pre-adder: B, D+B or D-B in B_WIDTH+1 bits.
    always_comb begin
        pre_s = {b1_r[B_WIDTH-1], b1_r};
        if (!op1_r[0]) begin
            pre_s = {b1_r[B_WIDTH-1], b1_r};
        end else if (op1_r[1]) begin
            pre_s = {d1_r[B_WIDTH-1], d1_r} - {b1_r[B_WIDTH-1], b1_r};
        end else begin
            pre_s = {d1_r[B_WIDTH-1], d1_r} + {b1_r[B_WIDTH-1], b1_r};
        end
    end

    // Multiplier: both operands widened to the exact product width first.
    always_comb begin
        m_s = $signed({{(MW-A_WIDTH){a2_r[A_WIDTH-1]}}, a2_r})
            * $signed({{(MW-PW){pre2_r[PW-1]}}, pre2_r});
    end

    // Post-adder with overflow detection and clamp/wrap selection.
    always_comb begin
        first_s = (cnt_r == {CW{1'b0}});
        close_s = last3_r || (cnt_r == CW'(ACC_LEN - 1));
        z_s     = acc_r;
        if (!mode3_r[1] || first_s) begin
            z_s = c3_r;
        end else begin
            z_s = acc_r;
        end
        if (mode3_r[0]) begin
            sum_s = {z_s[P_WIDTH-1], z_s} - {{(P_WIDTH+1-MW){m3_r[MW-1]}}, m3_r};
        end else begin
            sum_s = {z_s[P_WIDTH-1], z_s} + {{(P_WIDTH+1-MW){m3_r[MW-1]}}, m3_r};
        end
        ovf_s = sum_s[P_WIDTH] ^ sum_s[P_WIDTH-1];
        res_s = sum_s[P_WIDTH-1:0];
        if (ovf_s && SAT_EN) begin
            res_s = sum_s[P_WIDTH] ? P_MIN : P_MAX;
        end else begin
            res_s = sum_s[P_WIDTH-1:0];
        end
    end

    // Stages 1-3: operand, pre-adder and product registers, frozen on stall.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            v1_r <= 1'b0; last1_r <= 1'b0; a1_r <= '0; b1_r <= '0; d1_r <= '0;
            c1_r <= '0; op1_r <= 4'b0000;
            v2_r <= 1'b0; last2_r <= 1'b0; a2_r <= '0; pre2_r <= '0;
            c2_r <= '0; mode2_r <= 2'b00;
            v3_r <= 1'b0; last3_r <= 1'b0; m3_r <= '0; c3_r <= '0; mode3_r <= 2'b00;
        end else if (!stall_s) begin
            v1_r    <= IN_VALID;
            last1_r <= IN_LAST;
            a1_r    <= A;
            b1_r    <= B;
            d1_r    <= D;
            c1_r    <= C;
            op1_r   <= OPMODE;
            v2_r    <= v1_r;
            last2_r <= last1_r;
            a2_r    <= a1_r;
            pre2_r  <= pre_s;
            c2_r    <= c1_r;
            mode2_r <= op1_r[3:2];
            v3_r    <= v2_r;
            last3_r <= last2_r;
            m3_r    <= m_s;
            c3_r    <= c2_r;
            mode3_r <= mode2_r;
        end
    end

    // Stage 4: accumulator, group bookkeeping and result registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            acc_r       <= '0;
            cnt_r       <= {CW{1'b0}};
            grp_ovf_r   <= 1'b0;
            sticky_r    <= 1'b0;
            p_r         <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (!stall_s) begin
            if (v3_r) begin
                acc_r <= res_s;
                if (ovf_s) begin
                    sticky_r <= 1'b1;
                end
                if (!mode3_r[1]) begin
                    // a plain MAC sample also abandons any open group
                    out_valid_r <= 1'b1;
                    p_r         <= res_s;
                    out_last_r  <= 1'b1;
                    ovf_r       <= ovf_s;
                    cnt_r       <= {CW{1'b0}};
                    grp_ovf_r   <= 1'b0;
                end else if (close_s) begin
                    out_valid_r <= 1'b1;
                    p_r         <= res_s;
                    out_last_r  <= 1'b1;
                    ovf_r       <= grp_ovf_r | ovf_s;
                    cnt_r       <= {CW{1'b0}};
                    grp_ovf_r   <= 1'b0;
                end else begin
                    out_valid_r <= 1'b0;
                    cnt_r       <= cnt_r + CW'(1);
                    grp_ovf_r   <= grp_ovf_r | ovf_s;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: default, ACC_LEN=4, saturating and wrapping
// 37-bit instances, each with its own valid/ready and a result queue.
module tb_dsp_mac_pipe;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic out_ready = 1'b1;
    logic signed [17:0] a_s = '0, b_s = '0, d_s = '0;
    logic signed [47:0] c48_s = '0;
    logic signed [36:0] c37_s = '0;
    logic [3:0] op_s = 4'b0000;
    logic last_s = 1'b0;
    logic [3:0] iv_s = 4'b0000;
    logic [3:0] ir_s, ov_s, ol_s, of_s, os_s;
    logic signed [47:0] p_main, p_acc4;
    logic signed [36:0] p_sat, p_wrap;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic signed [63:0] p; logic last; logic ovf; } res_t;
    res_t q0[$], q1[$], q2[$], q3[$];

    always #5 CLK = ~CLK;

    dsp_mac_pipe u_main (.CLK(CLK), .RSTN(RSTN), .IN_VALID(iv_s[0]), .IN_READY(ir_s[0]),
        .IN_LAST(last_s), .A(a_s), .B(b_s), .D(d_s), .C(c48_s), .OPMODE(op_s),
        .OUT_VALID(ov_s[0]), .OUT_READY(out_ready), .P(p_main), .OUT_LAST(ol_s[0]),
        .OVF(of_s[0]), .OVF_STICKY(os_s[0]));
    dsp_mac_pipe #(.ACC_LEN(4)) u_acc4 (.CLK(CLK), .RSTN(RSTN), .IN_VALID(iv_s[1]),
        .IN_READY(ir_s[1]), .IN_LAST(last_s), .A(a_s), .B(b_s), .D(d_s), .C(c48_s),
        .OPMODE(op_s), .OUT_VALID(ov_s[1]), .OUT_READY(out_ready), .P(p_acc4),
        .OUT_LAST(ol_s[1]), .OVF(of_s[1]), .OVF_STICKY(os_s[1]));
    dsp_mac_pipe #(.P_WIDTH(37)) u_sat (.CLK(CLK), .RSTN(RSTN), .IN_VALID(iv_s[2]),
        .IN_READY(ir_s[2]), .IN_LAST(last_s), .A(a_s), .B(b_s), .D(d_s), .C(c37_s),
        .OPMODE(op_s), .OUT_VALID(ov_s[2]), .OUT_READY(out_ready), .P(p_sat),
        .OUT_LAST(ol_s[2]), .OVF(of_s[2]), .OVF_STICKY(os_s[2]));
    dsp_mac_pipe #(.P_WIDTH(37), .SATURATE(0)) u_wrap (.CLK(CLK), .RSTN(RSTN),
        .IN_VALID(iv_s[3]), .IN_READY(ir_s[3]), .IN_LAST(last_s), .A(a_s), .B(b_s),
        .D(d_s), .C(c37_s), .OPMODE(op_s), .OUT_VALID(ov_s[3]), .OUT_READY(out_ready),
        .P(p_wrap), .OUT_LAST(ol_s[3]), .OVF(of_s[3]), .OVF_STICKY(os_s[3]));

    // Record every result transfer, sampled on the falling edge.
    always @(negedge CLK) begin
        res_t r;
        if (RSTN && out_ready) begin
            if (ov_s[0]) begin r.p = p_main; r.last = ol_s[0]; r.ovf = of_s[0]; q0.push_back(r); end
            if (ov_s[1]) begin r.p = p_acc4; r.last = ol_s[1]; r.ovf = of_s[1]; q1.push_back(r); end
            if (ov_s[2]) begin r.p = p_sat;  r.last = ol_s[2]; r.ovf = of_s[2]; q2.push_back(r); end
            if (ov_s[3]) begin r.p = p_wrap; r.last = ol_s[3]; r.ovf = of_s[3]; q3.push_back(r); end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int sel, input logic signed [17:0] a, input logic signed [17:0] b,
                        input logic signed [17:0] d, input logic signed [47:0] c,
                        input logic [3:0] op, input logic last);
        bit ok;
        bit done;
        done = 1'b0;
        a_s = a; b_s = b; d_s = d; c48_s = c; c37_s = c[36:0]; op_s = op; last_s = last;
        iv_s = 4'b0001 << sel;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge CLK);
            ok = ir_s[sel];
            @(posedge CLK);
            #1;
            done = ok;
        end
        iv_s = 4'b0000;
        last_s = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic pop_chk(input int sel, input string tag, input logic signed [63:0] p, input logic ovf);
        res_t r;
        int sz;
        case (sel)
            0: sz = q0.size();
            1: sz = q1.size();
            2: sz = q2.size();
            default: sz = q3.size();
        endcase
        chk({tag, "_avail"}, sz > 0, 1);
        if (sz > 0) begin
            case (sel)
                0: r = q0.pop_front();
                1: r = q1.pop_front();
                2: r = q2.pop_front();
                default: r = q3.pop_front();
            endcase
            chk({tag, "_p"}, r.p, p);
            chk({tag, "_last"}, r.last, 1);
            chk({tag, "_ovf"}, r.ovf, ovf);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int cyc;
        bit saw_stall;
        logic prev_ov;
        logic signed [47:0] prev_p;

        // Reset values with no clock edge yet.
        #2;
        chk("rst_out_valid", ov_s[0], 0);
        chk("rst_p", p_main, 0);
        chk("rst_out_last", ol_s[0], 0);
        chk("rst_ovf", of_s[0], 0);
        chk("rst_sticky", os_s[0], 0);
        chk("rst_in_ready", ir_s[0], 1);
        @(negedge CLK);
        RSTN = 1'b1;
        wait_cycles(2);

        // Single MAC: 3*(10+4)+100 = 142, result visible in the 4th cycle.
        send(0, 18'sd3, 18'sd4, 18'sd10, 48'sd100, 4'b0001, 1'b0);
        cyc = 1;
        for (int t = 0; t < 10; t++) begin
            if (ov_s[0]) break;
            @(posedge CLK);
            #1;
            cyc++;
        end
        chk("mac_latency", cyc, 4);
        chk("mac_p", p_main, 142);
        chk("mac_last", ol_s[0], 1);
        chk("mac_ovf", of_s[0], 0);
        wait_cycles(2);
        q0.delete();

        // Accumulate: 7 + 2*(1+2+3+4+5) = 37, one result only.
        for (int i = 1; i <= 5; i++)
            send(0, 18'sd2, 18'(i), 18'sd0, 48'sd7, 4'b1000, i == 5);
        wait_cycles(8);
        chk("acc_count", q0.size(), 1);
        pop_chk(0, "acc", 37, 1'b0);

        // ACC_LEN=4 forced group closes: 4, 4, then 2 on IN_LAST.
        for (int i = 1; i <= 10; i++)
            send(1, 18'sd1, 18'sd1, 18'sd0, 48'sd0, 4'b1000, i == 10);
        wait_cycles(8);
        chk("len4_count", q1.size(), 3);
        pop_chk(1, "len4_r0", 4, 1'b0);
        pop_chk(1, "len4_r1", 4, 1'b0);
        pop_chk(1, "len4_r2", 2, 1'b0);

        // 37-bit overflow: (2^36-1)+1 clamps or wraps.
        send(2, 18'sd1, 18'sd1, 18'sd0, 48'sh0F_FFFF_FFFF, 4'b0000, 1'b0);
        send(3, 18'sd1, 18'sd1, 18'sd0, 48'sh0F_FFFF_FFFF, 4'b0000, 1'b0);
        wait_cycles(8);
        pop_chk(2, "sat", 64'sh0F_FFFF_FFFF, 1'b1);
        chk("sat_sticky", os_s[2], 1);
        pop_chk(3, "wrap", -64'sh10_0000_0000, 1'b1);
        chk("wrap_sticky", os_s[3], 1);
        chk("main_sticky_clear", os_s[0], 0);

        // Backpressure: 8 plain samples, OUT_READY low for 6 cycles mid-stream.
        saw_stall = 1'b0;
        prev_ov = 1'b0;
        prev_p = '0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(0, 18'(i + 1), 18'sd2, 18'sd0, 48'(100 * i), 4'b0000, 1'b0);
            end
            begin
                repeat (5) @(posedge CLK);
                #1;
                out_ready = 1'b0;
                repeat (6) begin
                    @(negedge CLK);
                    if (ov_s[0] && prev_ov) chk("bp_p_stable", p_main, prev_p);
                    prev_ov = ov_s[0];
                    prev_p = p_main;
                    if (!ir_s[0]) saw_stall = 1'b1;
                    @(posedge CLK);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        wait_cycles(8);
        chk("bp_in_ready_dropped", saw_stall, 1);
        chk("bp_count", q0.size(), 8);
        for (int i = 0; i < 8; i++)
            pop_chk(0, $sformatf("bp_r%0d", i), 2 * (i + 1) + 100 * i, 1'b0);

        // Reset mid-group: clears outputs without a clock, no stale result after.
        for (int i = 0; i < 3; i++)
            send(0, 18'sd1, 18'sd1, 18'sd0, 48'sd5, 4'b1000, 1'b0);
        #1;
        RSTN = 1'b0;
        #1;
        chk("mid_rst_out_valid", ov_s[0], 0);
        chk("mid_rst_p", p_main, 0);
        chk("mid_rst_out_last", ol_s[0], 0);
        chk("mid_rst_in_ready", ir_s[0], 1);
        chk("mid_rst_sticky", os_s[2], 0);
        #1;
        RSTN = 1'b1;
        send(0, 18'sd1, 18'sd3, 18'sd0, 48'sd10, 4'b1000, 1'b0);
        send(0, 18'sd1, 18'sd3, 18'sd0, 48'sd10, 4'b1000, 1'b1);
        wait_cycles(8);
        chk("post_rst_count", q0.size(), 1);
        pop_chk(0, "post_rst", 16, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
